// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and constants for the mux scan sequencer
package mux_scan_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/scan_shift4.sv
// rtl/scan_shift4.sv - 4-bit capture register, channel k lands in bit (3-k)
module scan_shift4
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [SEL_W-1:0] idx,
  input  logic             bit_in,
  output logic [N_CH-1:0]  q,
  output logic [N_CH-1:0]  q_nxt
);

  localparam logic [SEL_W-1:0] TOP_IDX = SEL_W'(N_CH - 1);

  // q_nxt lets the owner latch the frame in the same cycle as the last capture
  always_comb begin
    q_nxt = q;
    if (clr)
      q_nxt = '0;
    else if (load)
      q_nxt[TOP_IDX - idx] = bit_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else
      q <= q_nxt;
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - steps a 4-to-1 mux through its channels and emits 4-bit frames
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       abort,
  output logic       s0,
  output logic       s1,
  input  logic       mux_out,
  output logic [3:0] frame_data,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy,
  output logic [7:0] frame_count
);

  // With no settle time every channel window is just its SAMPLE cycle
  localparam scan_state_e       FIRST_ST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
  localparam logic [CNT_W-1:0]  CNT_LAST = (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0]  LAST_CH  = SEL_W'(N_CH - 1);

  scan_state_e       state;
  logic [SEL_W-1:0]  k;
  logic [CNT_W-1:0]  cnt;
  logic [N_CH-1:0]   shift_q;
  logic [N_CH-1:0]   shift_nxt;
  logic              shift_clr;
  logic              shift_load;

  assign s0 = k[1];
  assign s1 = k[0];

  assign shift_clr  = (state == ST_IDLE) || abort;
  assign shift_load = (state == ST_SAMPLE);

  scan_shift4 u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (shift_clr),
    .load   (shift_load),
    .idx    (k),
    .bit_in (mux_out),
    .q      (shift_q),
    .q_nxt  (shift_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      k           <= '0;
      cnt         <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
    end else if (abort && state != ST_IDLE) begin
      state       <= ST_IDLE;
      k           <= '0;
      cnt         <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state <= FIRST_ST;
            k     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST)
            state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (k == LAST_CH) begin
            frame_data  <= shift_nxt;
            frame_valid <= 1'b1;
            state       <= ST_HOLD;
          end else begin
            k     <= k + 1'b1;
            cnt   <= '0;
            state <= FIRST_ST;
          end
        end
        ST_HOLD: begin
          // select stays on the last channel until the frame is taken
          if (frame_ready) begin
            frame_valid <= 1'b0;
            frame_count <= frame_count + 1'b1;
            if (cont) begin
              state <= FIRST_ST;
              k     <= '0;
              cnt   <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - scoreboard bench for mux_scan_ctrl (SETTLE=2 and SETTLE=0 builds)
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start = 0, cont = 0, abort = 0, ready = 0;
  logic [3:0] ins = 4'b0000;
  logic       s0, s1, mux_out, fv, busy;
  logic [3:0] fd;
  logic [7:0] fc;

  logic       start0 = 0, cont0 = 0, abort0 = 0, ready0 = 1;
  logic [3:0] ins0 = 4'b0000;
  logic       s0_0, s1_0, mux_out0, fv0, busy0;
  logic [3:0] fd0;
  logic [7:0] fc0;

  int n_cmp = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp0_q[$];

  always #5 clk = ~clk;

  // ins = {i0,i1,i2,i3}: channel 0 is ins[3]
  assign mux_out  = ins[2'd3 - {s0, s1}];
  assign mux_out0 = ins0[2'd3 - {s0_0, s1_0}];

  mux_scan_ctrl #(.SETTLE(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
    .s0(s0), .s1(s1), .mux_out(mux_out), .frame_data(fd), .frame_valid(fv),
    .frame_ready(ready), .busy(busy), .frame_count(fc)
  );

  mux_scan_ctrl #(.SETTLE(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cont(cont0), .abort(abort0),
    .s0(s0_0), .s1(s1_0), .mux_out(mux_out0), .frame_data(fd0), .frame_valid(fv0),
    .frame_ready(ready0), .busy(busy0), .frame_count(fc0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  // Monitors: every accepted frame must match the oldest expected frame
  always @(negedge clk) begin
    if (rst_n && fv && ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_frame: got %0h expected none at %0t", fd, $time);
      end else begin
        check("frame_data", {28'd0, fd}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && fv0 && ready0) begin
      if (exp0_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_frame0: got %0h expected none at %0t", fd0, $time);
      end else begin
        check("frame_data0", {28'd0, fd0}, {28'd0, exp0_q.pop_front()});
      end
    end
  end

  initial begin
    bit got;

    // reset values
    repeat (3) tick();
    check("rst_sel", {30'd0, s0, s1}, 32'd0);
    check("rst_fv", {31'd0, fv}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fc", {24'd0, fc}, 32'd0);
    check("rst_fd", {28'd0, fd}, 32'd0);
    rst_n = 1'b1;
    tick();

    // reset mid-scan at cycle 7
    ins = 4'b1111; ready = 1'b1;
    pulse_start();
    repeat (7) tick();
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", {30'd0, s0, s1}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_fv", {31'd0, fv}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("mid_post_fv", {31'd0, fv}, 32'd0);
    check("mid_post_busy", {31'd0, busy}, 32'd0);
    check("mid_post_fc", {24'd0, fc}, 32'd0);

    // one-shot, select sequence and 12-cycle latency
    ins = 4'b1011; ready = 1'b1; cont = 1'b0;
    exp_q.push_back(4'b1011);
    pulse_start();
    for (int j = 0; j <= 12; j++) begin
      if (j < 12) check($sformatf("os_sel_%0d", j), {30'd0, s0, s1}, j / 3);
      check($sformatf("os_fv_%0d", j), {31'd0, fv}, (j == 12) ? 32'd1 : 32'd0);
      tick();
    end
    check("os_fc", {24'd0, fc}, 32'd1);
    check("os_busy_idle", {31'd0, busy}, 32'd0);
    check("os_fv_clear", {31'd0, fv}, 32'd0);

    // back-pressure
    ready = 1'b0;
    exp_q.push_back(4'b1011);
    pulse_start();
    got = 0;
    for (int j = 0; j < 20 && !got; j++) begin
      if (fv) got = 1;
      else tick();
    end
    check("bp_valid_seen", {31'd0, got}, 32'd1);
    for (int j = 0; j < 20; j++) begin
      tick();
      check("bp_hold_fv", {31'd0, fv}, 32'd1);
      check("bp_hold_fd", {28'd0, fd}, 32'hB);
      check("bp_hold_sel", {30'd0, s0, s1}, 32'd3);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("bp_fv_drop", {31'd0, fv}, 32'd0);
    check("bp_fc", {24'd0, fc}, 32'd2);

    // continuous: three frames, inputs change during frame 2
    ready = 1'b1; cont = 1'b1; ins = 4'b1011;
    exp_q.push_back(4'b1011);
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b0110);
    pulse_start();
    for (int j = 0; j <= 45; j++) begin
      if (j == 20) ins = 4'b0110;
      if (j == 30) cont = 1'b0;
      check($sformatf("cont_fv_%0d", j), {31'd0, fv},
            (j == 12 || j == 25 || j == 38) ? 32'd1 : 32'd0);
      if (j == 13 || j == 26) check("cont_sel_restart", {30'd0, s0, s1}, 32'd0);
      tick();
    end
    check("cont_fc", {24'd0, fc}, 32'd5);
    check("cont_busy_idle", {31'd0, busy}, 32'd0);

    // abort during channel 2 settle
    ins = 4'b1111;
    pulse_start();
    repeat (7) tick();
    check("ab_sel_ch2", {30'd0, s0, s1}, 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_sel", {30'd0, s0, s1}, 32'd0);
    check("ab_busy", {31'd0, busy}, 32'd0);
    for (int j = 0; j < 20; j++) begin
      check("ab_fv", {31'd0, fv}, 32'd0);
      tick();
    end
    check("ab_fc", {24'd0, fc}, 32'd5);

    // abort and start together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abst_busy", {31'd0, busy}, 32'd0);
    for (int j = 0; j < 15; j++) begin
      check("abst_fv", {31'd0, fv}, 32'd0);
      tick();
    end
    check("abst_fc", {24'd0, fc}, 32'd5);

    // SETTLE=0: 4-cycle frames, all 16 patterns
    for (int p = 0; p < 16; p++) begin
      ins0 = 4'(p);
      exp0_q.push_back(4'(p));
      pulse_start0();
      for (int j = 0; j <= 4; j++) begin
        if (j < 4) check($sformatf("s0_sel_%0d_%0d", p, j), {30'd0, s0_0, s1_0}, j);
        check($sformatf("s0_fv_%0d_%0d", p, j), {31'd0, fv0}, (j == 4) ? 32'd1 : 32'd0);
        tick();
      end
    end
    check("s0_fc", {24'd0, fc0}, 32'd16);

    tick();
    check("queue_empty", exp_q.size(), 32'd0);
    check("queue0_empty", exp0_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
